// File: rtl/periph_arb_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// periph_arb_pkg : shared types/constants for the peripheral RR arbiter
// Revision: 1.0
// ---------------------------------------------------------------------------
package periph_arb_pkg;

   localparam int PERIPH_ARB_MAX_NB_REQ      = 16;
   localparam int PERIPH_ARB_MAX_OUTSTANDING = 8;

   // Wide enough for any legal requester count.
   typedef logic [$clog2(PERIPH_ARB_MAX_NB_REQ)-1:0] req_idx_t;

endpackage
`default_nettype wire

// File: rtl/periph_arb_id_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// periph_arb_id_fifo : in-order FIFO of granted requester indices
// Revision: 1.0
// ---------------------------------------------------------------------------
module periph_arb_id_fifo #(
   parameter int DEPTH = 2
) (
   input  logic                    clk,
   input  logic                    rst_i,
   input  logic                    push,
   input  periph_arb_pkg::req_idx_t push_id,
   input  logic                    pop,
   output periph_arb_pkg::req_idx_t head,
   output logic                    full,
   output logic                    empty
);
   import periph_arb_pkg::*;

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   req_idx_t             mem [DEPTH];
   logic [PTR_W-1:0]     wr_ptr;
   logic [PTR_W-1:0]     rd_ptr;
   logic [CNT_W-1:0]     count;
   logic                 push_en;
   logic                 pop_en;

   function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] ptr);
      return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
   endfunction

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign push_en = push && !full;
   assign pop_en  = pop && !empty;
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_en) wr_ptr <= bump(wr_ptr);
         if (pop_en)  rd_ptr <= bump(rd_ptr);
         case ({push_en, pop_en})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage holds only indices; validity is tracked by count, so no reset.
   always_ff @(posedge clk) begin
      if (push_en) mem[wr_ptr] <= push_id;
   end

endmodule
`default_nettype wire

// File: rtl/periph_rr_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// periph_rr_arbiter : N-to-1 round-robin arbiter with in-order response routing
// Optional: PERIPH_ARB_PRIO0_EN gives requester 0 fixed top priority.
// Revision: 1.0
// ---------------------------------------------------------------------------
module periph_rr_arbiter #(
   parameter int NB_REQ          = 4,
   parameter int ADDR_WIDTH      = 32,
   parameter int DATA_WIDTH      = 32,
   parameter int BE_WIDTH        = DATA_WIDTH / 8,
   parameter int MAX_OUTSTANDING = 2
) (
   input  logic                                clk,
   input  logic                                rst_i,
   input  logic [NB_REQ-1:0]                   data_req_i,
   input  logic [NB_REQ-1:0][ADDR_WIDTH-1:0]   data_add_i,
   input  logic [NB_REQ-1:0]                   data_wen_i,
   input  logic [NB_REQ-1:0][DATA_WIDTH-1:0]   data_wdata_i,
   input  logic [NB_REQ-1:0][BE_WIDTH-1:0]     data_be_i,
   output logic [NB_REQ-1:0]                   data_gnt_o,
   output logic [NB_REQ-1:0]                   data_r_valid_o,
   output logic [DATA_WIDTH-1:0]               data_r_rdata_o,
   output logic                                data_r_opc_o,
   output logic                                data_req_o,
   output logic [ADDR_WIDTH-1:0]               data_add_o,
   output logic                                data_wen_o,
   output logic [DATA_WIDTH-1:0]               data_wdata_o,
   output logic [BE_WIDTH-1:0]                 data_be_o,
   input  logic                                data_gnt_i,
   input  logic                                data_r_valid_i,
   input  logic [DATA_WIDTH-1:0]               data_r_rdata_i,
   input  logic                                data_r_opc_i,
   output logic                                spurious_rvalid_o
);
   import periph_arb_pkg::*;

   localparam int FIFO_DEPTH = (MAX_OUTSTANDING > PERIPH_ARB_MAX_OUTSTANDING) ?
                               PERIPH_ARB_MAX_OUTSTANDING : MAX_OUTSTANDING;

   req_idx_t rr_ptr;
   req_idx_t winner;
   req_idx_t hi_idx;
   req_idx_t lo_idx;
   req_idx_t next_ptr;
   req_idx_t head;
   logic     hi_found;
   logic     fifo_full;
   logic     fifo_empty;
   logic     handshake;
   logic     pop;
   logic     move_ptr;

   // Two-pass search: lowest requester at/above rr_ptr, else lowest overall.
   always_comb begin
      hi_found = 1'b0;
      hi_idx   = rr_ptr;
      lo_idx   = rr_ptr;
      for (int i = NB_REQ - 1; i >= 0; i--) begin
         if (data_req_i[i]) begin
            lo_idx = req_idx_t'(i);
            if (req_idx_t'(i) >= rr_ptr) begin
               hi_found = 1'b1;
               hi_idx   = req_idx_t'(i);
            end
         end
      end
      winner = hi_found ? hi_idx : lo_idx;
`ifdef PERIPH_ARB_PRIO0_EN
      if (data_req_i[0]) winner = '0;
`endif
   end

   always_comb begin
      data_add_o   = '0;
      data_wen_o   = 1'b1;
      data_wdata_o = '0;
      data_be_o    = '0;
      for (int i = 0; i < NB_REQ; i++) begin
         if (req_idx_t'(i) == winner) begin
            data_add_o   = data_add_i[i];
            data_wen_o   = data_wen_i[i];
            data_wdata_o = data_wdata_i[i];
            data_be_o    = data_be_i[i];
         end
      end
   end

   assign data_req_o     = (|data_req_i) && !fifo_full;
   assign handshake      = data_req_o && data_gnt_i;
   assign pop            = data_r_valid_i && !fifo_empty;
   assign data_r_rdata_o = data_r_rdata_i;
   assign data_r_opc_o   = data_r_opc_i;

   generate
      for (genvar g = 0; g < NB_REQ; g++) begin : g_req
         assign data_gnt_o[g]     = handshake && (winner == req_idx_t'(g));
         assign data_r_valid_o[g] = pop && (head == req_idx_t'(g));
      end
   endgenerate

   assign next_ptr = (winner == req_idx_t'(NB_REQ - 1)) ? '0 : winner + req_idx_t'(1);

`ifdef PERIPH_ARB_PRIO0_EN
   assign move_ptr = handshake && (winner != '0);
`else
   assign move_ptr = handshake;
`endif

   always_ff @(posedge clk or posedge rst_i) begin
      if (rst_i) begin
         rr_ptr            <= '0;
         spurious_rvalid_o <= 1'b0;
      end else begin
         if (move_ptr) rr_ptr <= next_ptr;
         spurious_rvalid_o <= data_r_valid_i && fifo_empty;
      end
   end

   periph_arb_id_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_id_fifo (
      .clk     (clk),
      .rst_i   (rst_i),
      .push    (handshake),
      .push_id (winner),
      .pop     (pop),
      .head    (head),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

endmodule
`default_nettype wire
